// File: rtl/updown_counter_pkg.sv
// Shared definitions for the up/down counter: default widths, FSM state
// encoding and flag bit positions in the slave's control-register extension.
package updown_counter_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int PRE_W_DEF = 8;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Bit positions of the sticky flags as seen by the control slave.
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_UNF   = 3;
    localparam int FLAG_MATCH = 4;

endpackage

// File: rtl/updown_prescaler.sv
// Prescaler for the up/down counter. Counts enabled edges and flags the
// edge on which pre_cnt has reached the reload value. pre_cnt is forced to 0
// while disabled or when cleared by a load.
module updown_prescaler #(
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [PRE_W-1:0] prescale,
    output logic             step_en
);

    logic [PRE_W-1:0] pre_cnt_q;
    logic [PRE_W-1:0] pre_cnt_d;

    // Reload compare uses the live prescale value, so a reduced value that is
    // already passed lets pre_cnt run on to its natural wrap before matching.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch cannot be inferred.
        pre_cnt_d = pre_cnt_q;
        step_en   = 1'b0;
        if (!en || clr) begin
            pre_cnt_d = '0;
            step_en   = en && (pre_cnt_q == prescale);
        end else if (pre_cnt_q == prescale) begin
            pre_cnt_d = '0;
            step_en   = 1'b1;
        end else begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
        end
    end

    // Prescaler state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) pre_cnt_q <= '0;
        else        pre_cnt_q <= pre_cnt_d;
    end

endmodule

// File: rtl/updown_counter.sv
// Up/down counter core behind the WISHBONE control slave: prescaled
// stepping, synchronous load, sticky ovf/unf/match flags and a registered
// interrupt. Optional compare logic is built when UPDOWN_CMP_EN is defined.
module updown_counter
    import updown_counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int PRE_W = PRE_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [PRE_W-1:0] prescale,
    input  logic [WIDTH-1:0] cmp_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             ovf,
    output logic             unf,
    output logic             match,
    output logic             irq
);

    state_e           state_q, state_d;
    logic             step_en;
    logic [WIDTH-1:0] step_cnt;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             ovf_q, ovf_d, ovf_set;
    logic             unf_q, unf_d, unf_set;
    logic             match_q, match_d, match_set;
    logic             irq_q, irq_d;
    logic             step_ok;

    // Run/stop FSM: follows en; the edge that sees en=1 already counts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            STOP:    if (en)  state_d = RUN;
            RUN:     if (!en) state_d = STOP;
            default: state_d = STOP;
        endcase
    end

    updown_prescaler #(
        .PRE_W(PRE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (state_d == RUN),
        .clr      (load),
        .prescale (prescale),
        .step_en  (step_en)
    );

    // A load in the same cycle swallows the step entirely.
    assign step_ok  = step_en && !load;
    assign step_cnt = up_down ? count_q + WIDTH'(1) : count_q - WIDTH'(1);

    // Count update, tick and wrap detection.
    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (step_ok) begin
            count_d = step_cnt;
            tick_d  = 1'b1;
            ovf_set = up_down && (count_q == '1);
            unf_set = !up_down && (count_q == '0);
        end
    end

`ifdef UPDOWN_CMP_EN
    // Compare only against stepped values, never loaded ones.
    assign match_set = step_ok && (step_cnt == cmp_val);
`else
    logic unused_cmp;
    assign unused_cmp = ^cmp_val;
    assign match_set  = 1'b0;
`endif

    // Sticky flags: a set in the same cycle as a clear wins.
    always_comb begin
        ovf_d   = ovf_set   || (ovf_q   && !clr_flags);
        unf_d   = unf_set   || (unf_q   && !clr_flags);
        match_d = match_set || (match_q && !clr_flags);
        irq_d   = ovf_q || unf_q || match_q;
    end

    // Output and state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STOP;
            count_q <= '0;
            tick_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            match_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            match_q <= match_d;
            irq_q   <= irq_d;
        end
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;
    assign match = match_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_updown_counter.sv
// Self-checking bench for updown_counter: table of stimulus/expected records
// pushed through a scoreboard queue, plus hand sequences for prescale change
// mid-run and asynchronous reset. Honours UPDOWN_CMP_EN for match expectations.
module tb_updown_counter;

`ifdef UPDOWN_CMP_EN
    localparam bit CMP_ON = 1'b1;
`else
    localparam bit CMP_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        en, up_down, load, clr_flags;
    logic [31:0] load_val, cmp_val;
    logic [7:0]  prescale;
    logic [31:0] count;
    logic        tick, ovf, unf, match, irq;

    updown_counter #(.WIDTH(32), .PRE_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .up_down   (up_down),
        .load      (load),
        .load_val  (load_val),
        .prescale  (prescale),
        .cmp_val   (cmp_val),
        .clr_flags (clr_flags),
        .count     (count),
        .tick      (tick),
        .ovf       (ovf),
        .unf       (unf),
        .match     (match),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en, ud, ld;
        logic [31:0] lv;
        logic [7:0]  pre;
        logic        clr;
        logic [31:0] cnt;
        logic        tick, ovf, unf, match, irq;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] cnt;
        logic        tick, ovf, unf, match, irq;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic add(input logic e, input logic ud, input logic ld, input logic [31:0] lv,
                       input logic [7:0] pre, input logic clr, input logic [31:0] c,
                       input logic t, input logic o, input logic u, input logic m, input logic i);
        vec_t v;
        v.en = e; v.ud = ud; v.ld = ld; v.lv = lv; v.pre = pre; v.clr = clr;
        v.cnt = c; v.tick = t; v.ovf = o; v.unf = u; v.match = m; v.irq = i;
        vecs.push_back(v);
    endtask

    // Drive one vector at negedge, record expectation, compare after posedge.
    task automatic drive_cycle(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        @(negedge clk);
        en = v.en; up_down = v.ud; load = v.ld; load_val = v.lv;
        prescale = v.pre; clr_flags = v.clr;
        e.idx = idx; e.cnt = v.cnt; e.tick = v.tick; e.ovf = v.ovf;
        e.unf = v.unf; e.match = v.match; e.irq = v.irq;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            check($sformatf("v%0d.count", got.idx), count, got.cnt);
            check($sformatf("v%0d.tick",  got.idx), {31'd0, tick},  {31'd0, got.tick});
            check($sformatf("v%0d.ovf",   got.idx), {31'd0, ovf},   {31'd0, got.ovf});
            check($sformatf("v%0d.unf",   got.idx), {31'd0, unf},   {31'd0, got.unf});
            check($sformatf("v%0d.match", got.idx), {31'd0, match}, {31'd0, got.match});
            check($sformatf("v%0d.irq",   got.idx), {31'd0, irq},   {31'd0, got.irq});
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".count"}, count, 32'd0);
        check({tag, ".tick"},  {31'd0, tick},  32'd0);
        check({tag, ".ovf"},   {31'd0, ovf},   32'd0);
        check({tag, ".unf"},   {31'd0, unf},   32'd0);
        check({tag, ".match"}, {31'd0, match}, 32'd0);
        check({tag, ".irq"},   {31'd0, irq},   32'd0);
    endtask

    initial begin
        vec_t v;

        // ---- Stimulus/expectation table ------------------------------------
        // Free-running up count, prescale 0: a step every edge.
        for (int k = 1; k <= 5; k++) add(1, 1, 0, 0, 0, 0, k, 1, 0, 0, 0, 0);
        // Load 0 while stopped, then prescale 3: ticks on edges 4, 8, 12.
        add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 12; k++) add(1, 1, 0, 0, 3, 0, k / 4, (k % 4) == 0, 0, 0, 0, 0);
        // Overflow: load all-ones minus one, two up steps, irq one cycle later.
        add(0, 1, 1, 32'hFFFF_FFFE, 0, 0, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 32'h0,         1, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 32'h0,         0, 1, 0, 0, 1);
        add(0, 1, 0, 0, 0, 1, 32'h0,         0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0);
        // Underflow, then load 0 and underflow again with clr_flags: set wins.
        add(1, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 1, 0, 1, 0, 0);
        add(1, 0, 1, 0, 0, 0, 32'h0,         0, 0, 1, 0, 1);
        add(1, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 1, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
        // Compare (cmp_val = 7): loading 7 does not match, stepping onto 7 does.
        add(0, 1, 1, 7, 0, 0, 7, 0, 0, 0, 0,      0);
        add(1, 1, 0, 0, 0, 0, 8, 1, 0, 0, 0,      0);
        add(1, 0, 0, 0, 0, 0, 7, 1, 0, 0, CMP_ON, 0);
        add(0, 0, 0, 0, 0, 0, 7, 0, 0, 0, CMP_ON, CMP_ON);
        add(0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0,      CMP_ON);
        add(0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0,      0);
        // Prescale 1: load on the scheduled step edge wins, no tick.
        add(1, 1, 0, 0,   1, 0, 7,   0, 0, 0, 0, 0);
        add(1, 1, 1, 100, 1, 0, 100, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0,   1, 0, 100, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0,   1, 0, 101, 1, 0, 0, 0, 0);

        // ---- Reset ---------------------------------------------------------
        rst_n = 1'b0; en = 0; up_down = 0; load = 0; load_val = 0;
        prescale = 0; cmp_val = 32'd7; clr_flags = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // ---- Table ---------------------------------------------------------
        foreach (vecs[i]) drive_cycle(vecs[i], i);

        // ---- Prescale lowered below pre_cnt while running ------------------
        // Four edges at prescale 5 leave pre_cnt at 4; at prescale 2 it must
        // run to 255, wrap, and step only on the 255th edge.
        for (int k = 0; k < 4; k++) begin
            v = '{en: 1, ud: 1, ld: 0, lv: 0, pre: 5, clr: 0, cnt: 101,
                  tick: 0, ovf: 0, unf: 0, match: 0, irq: 0};
            drive_cycle(v, 1000 + k);
        end
        for (int k = 1; k <= 255; k++) begin
            v = '{en: 1, ud: 1, ld: 0, lv: 0, pre: 2, clr: 0,
                  cnt: (k == 255) ? 32'd102 : 32'd101, tick: (k == 255),
                  ovf: 0, unf: 0, match: 0, irq: 0};
            drive_cycle(v, 2000 + k);
        end

        // ---- Asynchronous reset mid-prescale -------------------------------
        for (int k = 0; k < 2; k++) begin
            v = '{en: 1, ud: 1, ld: 0, lv: 0, pre: 3, clr: 0, cnt: 102,
                  tick: 0, ovf: 0, unf: 0, match: 0, irq: 0};
            drive_cycle(v, 3000 + k);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        v = '{en: 0, ud: 1, ld: 0, lv: 0, pre: 0, clr: 0, cnt: 0,
              tick: 0, ovf: 0, unf: 0, match: 0, irq: 0};
        drive_cycle(v, 4000);
        // Fresh prescale count after reset: first step on the 4th edge.
        for (int k = 1; k <= 4; k++) begin
            v = '{en: 1, ud: 1, ld: 0, lv: 0, pre: 3, clr: 0,
                  cnt: (k == 4) ? 32'd1 : 32'd0, tick: (k == 4),
                  ovf: 0, unf: 0, match: 0, irq: 0};
            drive_cycle(v, 5000 + k);
        end

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/updown_counter.md
# updown_counter

Up/down counter core that sits directly downstream of the WISHBONE control slave: it consumes the slave's `en` and `up_down` control bits and produces the `count` value the slave returns on reads at address 0x4. It adds a programmable prescaler, synchronous load, sticky wrap flags and a compare-match flag. All flags are ORed onto a single interrupt line for the SoC.

## Interface
- `WIDTH`, 32: counter width in bits.
- `PRE_W`, 8: prescaler reload width in bits.

- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  count enable, from the slave.
- `up_down`  in  1  1 = count up, 0 = count down, from the slave.
- `load`  in  1  one-cycle pulse that loads `load_val`.
- `load_val`  in  WIDTH  value to load.
- `prescale`  in  PRE_W  one step per `prescale+1` enabled cycles.
- `cmp_val`  in  WIDTH  compare value.
- `clr_flags`  in  1  one-cycle pulse that clears `ovf`, `unf` and `match`.
- `count`  out  WIDTH  current count, to the slave.
- `tick`  out  1  one-cycle pulse in the cycle `count` has just stepped.
- `ovf`  out  1  sticky flag: up-wrap from all-ones to 0.
- `unf`  out  1  sticky flag: down-wrap from 0 to all-ones.
- `match`  out  1  sticky flag: a step landed on `cmp_val`.
- `irq`  out  1  `ovf | unf | match`, registered.

## Operation
- Two-state FSM, STOP and RUN.
  - STOP → RUN on an edge where `en`=1.
  - RUN → STOP on an edge where `en`=0.
- Prescaler `pre_cnt` (PRE_W bits):
  - Held at 0 in STOP.
  - In RUN, a step is taken when `pre_cnt == prescale`, and `pre_cnt` returns to 0; otherwise `pre_cnt` increments.
- Steps: `count ± 1` modulo 2^WIDTH, in the direction given by `up_down` sampled on the step edge. A direction change mid-prescale applies to the next step; the prescaler is not reset.
- Load:
  - `load`=1 sets `count` to `load_val` and clears `pre_cnt` to 0.
  - Load has priority over a step in the same cycle. That step is lost; no `tick` and no flag update.
  - Load works in STOP and in RUN.
- Flags:
  - `ovf` sets on an up-step from all-ones.
  - `unf` sets on a down-step from 0.
  - `match` sets when the post-step count equals `cmp_val`. A load that equals `cmp_val` does not set it.
  - A flag set and `clr_flags` in the same cycle: the set wins.
- `prescale` changed while running: the new value is compared immediately. If `pre_cnt` is already greater than the new `prescale`, `pre_cnt` runs up to its wrap at 2^PRE_W−1 and back to 0; no step occurs until the next match.

## Timing
- Reset values:
  - `count`=0, `tick`=0, `ovf`=`unf`=`match`=0, `irq`=0.
  - FSM in STOP, `pre_cnt`=0.
  - Reset mid-count aborts immediately (asynchronous).
- All outputs are registered. `irq` lags the flags by one cycle.
- With `prescale`=0, the first step occurs on the first edge that samples `en`=1. After that, one step per cycle.
- With `prescale`=P, the first step occurs on the (P+1)th edge with `en`=1. After that, one step per P+1 cycles.
- `tick` and the matching `count` change appear on the same edge.

## Configuration
- `UPDOWN_CMP_EN` defined: compare logic is present as described.
- `UPDOWN_CMP_EN` undefined:
  - `match` is tied to 0 and `cmp_val` is ignored (the port remains).
  - `irq = ovf | unf`.

## Structure
- Package `updown_counter_pkg` holds:
  - Default widths `WIDTH_DEF`=32 and `PRE_W_DEF`=8.
  - The FSM state enum (STOP, RUN).
  - Flag bit indices for the control-register extension: OVF=2, UNF=3, MATCH=4.
- One sub-module, `updown_prescaler`. It contains the `pre_cnt` register, the reload compare and the clear input, and outputs `step_en`.

## Test plan
- Reset, then `en`=1, `up_down`=1, `prescale`=0, run 5 cycles → `count`=5 and `tick` high on every cycle.
- `prescale`=3, up, 12 enabled cycles → `count`=3, with `tick` on cycles 4, 8 and 12 only.
- `load`=1 with `load_val`=0xFFFF_FFFE, then up for 2 steps → `count` goes 0xFFFF_FFFF then 0; `ovf`=1 and `irq`=1 one cycle later.
- `count`=0, down 1 step → `count`=0xFFFF_FFFF and `unf`=1. Then `clr_flags` in the same cycle as another underflow → `unf` stays 1.
- `cmp_val`=7, `load_val`=7 load → `match`=0. Then up to 8 and down to 7 → `match`=1 (only with `UPDOWN_CMP_EN`; stays 0 without it).
- `load` on the same edge as a scheduled step, and `rst_n` dropped mid-prescale → the load wins with no `tick`; the reset gives all outputs 0 asynchronously.
